cpu_ram_arb: RTL and testbench

Parametrised successor to `cpu_ram`: a single-ported word RAM shared by the CPU data (D) and instruction (I) ports through a request/grant arbiter, with configurable depth, read-pipeline latency and arbitration policy. It sits between the CPU core and on-chip memory where a true dual-port macro is unavailable. Each port issues at most one access per cycle and receives in-order, fixed-latency responses.

---
 rtl/cpu_ram_arb.sv | 122 ++++++++++++
 tb/tb_cpu_ram_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ram_arb.sv
// Single-ported word RAM shared by the CPU data (D) and instruction (I) ports.
// A request/grant arbiter allows one access per cycle; each port sees in-order, fixed-latency responses.
`timescale 1ns/1ps
module cpu_ram_arb #(
  parameter int    SIZE      = 13,
  parameter int    LATENCY   = 1,
  parameter int    ARB_MODE  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE+1:0] d_addr,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [31:0]     d_wdata,
  output logic            d_gnt,
  output logic [31:0]     d_rdata,
  output logic            d_valid,
  input  logic [SIZE+1:0] i_addr,
  input  logic            i_req,
  output logic            i_gnt,
  output logic [31:0]     i_rdata,
  output logic            i_valid
);

  // state  | meaning
  // LAST_I | I granted most recently (reset value); D wins the next conflict
  // LAST_D | D granted most recently; I wins the next conflict when ARB_MODE=1
  typedef enum logic {LAST_I = 1'b0, LAST_D = 1'b1} last_t;

  localparam int DEPTH = 1 << SIZE;

  last_t              last_q, last_nxt;
  logic [31:0]        mem [DEPTH];
  logic [SIZE-1:0]    acc_idx;
  logic [1:0]         gnt_v, rd_v, valid_v;
  logic [1:0][31:0]   rdata_q;
  logic               unused_addr_lsb;

  always_ff @(posedge clk) begin
    if (!reset) last_q <= LAST_I;
    else        last_q <= last_nxt;
  end

  always_comb begin
    last_nxt = last_q;
    if (d_gnt)      last_nxt = LAST_D;
    else if (i_gnt) last_nxt = LAST_I;
  end

  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (reset) begin
      if (d_req && (!i_req || ARB_MODE == 0 || last_q == LAST_I)) d_gnt = 1'b1;
      else if (i_req)                                            i_gnt = 1'b1;
    end
  end

  assign acc_idx         = d_gnt ? d_addr[SIZE+1:2] : i_addr[SIZE+1:2];
  assign gnt_v           = {i_gnt, d_gnt};
  assign rd_v            = {i_gnt, d_gnt & ~d_we};
  assign unused_addr_lsb = ^{d_addr[1:0], i_addr[1:0]};

  // Memory has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (d_gnt && d_we) begin
      for (int b = 0; b < 4; b++) begin
        if (d_be[b]) mem[acc_idx][8*b +: 8] <= d_wdata[8*b +: 8];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      logic [1:0] v_q;
      always_ff @(posedge clk) begin
        if (!reset) begin
          v_q     <= '0;
          rdata_q <= '0;
        end else begin
          v_q <= gnt_v;
          if (rd_v[0]) rdata_q[0] <= mem[acc_idx];
          if (rd_v[1]) rdata_q[1] <= mem[acc_idx];
        end
      end
      assign valid_v = v_q;
    end else begin : g_latn
      // One access per cycle, so a single data pipeline serves both ports.
      logic [1:0]  v_q   [LATENCY];
      logic [1:0]  r_q   [LATENCY-1];
      logic [31:0] dat_q [LATENCY-1];
      always_ff @(posedge clk) begin
        if (!reset) begin
          v_q     <= '{default: '0};
          r_q     <= '{default: '0};
          rdata_q <= '0;
        end else begin
          v_q[0]   <= gnt_v;
          r_q[0]   <= rd_v;
          dat_q[0] <= mem[acc_idx];
          for (int k = 1; k < LATENCY; k++) v_q[k] <= v_q[k-1];
          for (int k = 1; k < LATENCY - 1; k++) begin
            r_q[k]   <= r_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
          for (int p = 0; p < 2; p++) begin
            if (v_q[LATENCY-2][p] && r_q[LATENCY-2][p]) rdata_q[p] <= dat_q[LATENCY-2];
          end
        end
      end
      assign valid_v = v_q[LATENCY-1];
    end
  endgenerate

  assign d_valid = valid_v[0];
  assign i_valid = valid_v[1];
  assign d_rdata = rdata_q[0];
  assign i_rdata = rdata_q[1];

endmodule

// File: tb/tb_cpu_ram_arb.sv
// Scoreboard bench for cpu_ram_arb: u_a (LATENCY=1, round-robin) and u_b (LATENCY=3, fixed D priority).
// Stimulus pushes expected responses; a negedge monitor pops and checks data and arrival cycle.
`timescale 1ns/1ps
module tb_cpu_ram_arb;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic [1:0]       rst_n;
  logic [1:0]       d_req, d_we, i_req, d_gnt, i_gnt, d_valid, i_valid;
  logic [1:0][3:0]  d_be;
  logic [1:0][14:0] d_addr, i_addr;
  logic [1:0][31:0] d_wdata, d_rdata, i_rdata;
  logic [3:0]       vld_all;
  logic [3:0][31:0] rd_all;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb [4][$];
  logic [31:0] last_rd [4];
  logic [31:0] pat [8192];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vld_all = {i_valid[1], d_valid[1], i_valid[0], d_valid[0]};
  assign rd_all  = {i_rdata[1], d_rdata[1], i_rdata[0], d_rdata[0]};

  cpu_ram_arb #(.SIZE(13), .LATENCY(1), .ARB_MODE(1), .INIT_FILE("")) u_a (
    .clk(clk), .reset(rst_n[0]),
    .d_addr(d_addr[0]), .d_req(d_req[0]), .d_we(d_we[0]), .d_be(d_be[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rdata(d_rdata[0]), .d_valid(d_valid[0]),
    .i_addr(i_addr[0]), .i_req(i_req[0]),
    .i_gnt(i_gnt[0]), .i_rdata(i_rdata[0]), .i_valid(i_valid[0])
  );

  cpu_ram_arb #(.SIZE(13), .LATENCY(3), .ARB_MODE(0), .INIT_FILE("")) u_b (
    .clk(clk), .reset(rst_n[1]),
    .d_addr(d_addr[1]), .d_req(d_req[1]), .d_we(d_we[1]), .d_be(d_be[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rdata(d_rdata[1]), .d_valid(d_valid[1]),
    .i_addr(i_addr[1]), .i_req(i_req[1]),
    .i_gnt(i_gnt[1]), .i_rdata(i_rdata[1]), .i_valid(i_valid[1])
  );

  function automatic int lat(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endfunction

  // Write acks must leave rdata at the value of the previous read response.
  function automatic void push_exp(input int ch, input bit is_rd, input logic [31:0] d);
    exp_t e;
    e.cyc  = cyc + lat(ch / 2);
    e.data = is_rd ? d : last_rd[ch];
    if (is_rd) last_rd[ch] = d;
    sb[ch].push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int ch = 0; ch < 4; ch++) begin
      if (vld_all[ch] === 1'b1) begin
        if (sb[ch].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid ch=%0d cycle=%0d: actual=1 required=0", ch, cyc);
        end else begin
          e = sb[ch].pop_front();
          chk($sformatf("resp_cycle_ch%0d", ch), cyc, e.cyc);
          chk($sformatf("resp_rdata_ch%0d", ch), rd_all[ch], e.data);
        end
      end else if (sb[ch].size() != 0 && cyc > sb[ch][0].cyc) begin
        e = sb[ch].pop_front();
        checks++;
        errors++;
        $display("FAIL valid_timeout ch=%0d: actual=no valid required=valid at cycle %0d", ch, e.cyc);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (d_gnt[k] === 1'b1 || i_gnt[k] === 1'b1)
        chk($sformatf("gnt_exclusive_%0d", k), {31'd0, d_gnt[k] & i_gnt[k]}, 32'd0);
    end
  end

  task automatic issue(input int inst, input bit ip, input bit we, input logic [3:0] be,
                       input logic [14:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    int ch;
    bit got;
    ch  = inst * 2 + int'(ip);
    got = 1'b0;
    if (ip) begin
      i_addr[inst] = addr;
      i_req[inst]  = 1'b1;
    end else begin
      d_addr[inst]  = addr;
      d_we[inst]    = we;
      d_be[inst]    = be;
      d_wdata[inst] = wd;
      d_req[inst]   = 1'b1;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((ip ? i_gnt[inst] : d_gnt[inst]) === 1'b1) begin
        got = 1'b1;
        chk("gnt_immediate", n, 0);
        push_exp(ch, !we, exp_rd);
      end
      @(posedge clk); #1;
    end
    if (!got) chk("gnt_timeout", 0, 1);
    if (ip) i_req[inst] = 1'b0;
    else begin
      d_req[inst] = 1'b0;
      d_we[inst]  = 1'b0;
    end
  endtask

  task automatic do_reset(input int inst, input int ncyc);
    rst_n[inst] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sb[inst*2 + p].delete();
      last_rd[inst*2 + p] = '0;
    end
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n[inst] = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x;
    rst_n = 2'b00; d_req = 2'b11; i_req = 2'b11; d_we = '0; d_be = '0;
    d_addr = '0; i_addr = '0; d_wdata = '0;
    for (int c = 0; c < 4; c++) last_rd[c] = '0;

    // Requests held during reset must not be granted.
    @(posedge clk); #1; @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_d_gnt", d_gnt[k], 0);
      chk("reset_i_gnt", i_gnt[k], 0);
      chk("reset_d_valid", d_valid[k], 0);
      chk("reset_i_valid", i_valid[k], 0);
      chk("reset_d_rdata", d_rdata[k], 0);
      chk("reset_i_rdata", i_rdata[k], 0);
    end
    @(posedge clk); #1;
    d_req = '0; i_req = '0; rst_n = 2'b11;

    // Word write then immediate reads on both ports; low address bits ignored.
    issue(0, 0, 1, 4'hF, 15'h7FFC, 32'hDEADBEEF, 0);
    issue(0, 0, 0, 4'h0, 15'h7FFC, 0, 32'hDEADBEEF);
    issue(0, 1, 0, 4'h0, 15'h7FFF, 0, 32'hDEADBEEF);

    // Byte lanes: 11223344, then AABBCCDD on lanes 0 and 2, then no lanes.
    issue(0, 0, 1, 4'hF, 15'h0100, 32'h11223344, 0);
    issue(0, 0, 1, 4'h5, 15'h0100, 32'hAABBCCDD, 0);
    issue(0, 0, 1, 4'h0, 15'h0100, 32'hFFFFFFFF, 0);
    issue(0, 0, 0, 4'hF, 15'h0100, 0, 32'h11BB33DD);
    issue(0, 1, 0, 4'h0, 15'h0100, 0, 32'h11BB33DD);
    drain(4);

    // Round-robin: after reset D wins first, then strict alternation.
    do_reset(0, 2);
    @(negedge clk);
    chk("rst_clr_d_rdata", d_rdata[0], 0);
    chk("rst_clr_i_rdata", i_rdata[0], 0);
    @(posedge clk); #1;
    d_addr[0] = 15'h7FFC; d_we[0] = 1'b0; i_addr[0] = 15'h0100;
    d_req[0] = 1'b1; i_req[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_d_gnt", d_gnt[0], (k % 2 == 0) ? 1 : 0);
      chk("rr_i_gnt", i_gnt[0], (k % 2 == 1) ? 1 : 0);
      if (d_gnt[0] === 1'b1) push_exp(0, 1'b1, 32'hDEADBEEF);
      if (i_gnt[0] === 1'b1) push_exp(1, 1'b1, 32'h11BB33DD);
      @(posedge clk); #1;
    end
    d_req[0] = 1'b0; i_req[0] = 1'b0;
    drain(3);

    // LATENCY=3: preload words 0..7, then 8 back-to-back reads.
    for (int k = 0; k < 8; k++) issue(1, 0, 1, 4'hF, 15'(k * 4), 32'hA5A50000 + k, 0);
    for (int k = 0; k < 8; k++) issue(1, 0, 0, 4'h0, 15'(k * 4), 0, 32'hA5A50000 + k);
    drain(6);

    // Fixed priority: I starves while D requests, then is served.
    d_addr[1] = 15'h0000; d_we[1] = 1'b0; i_addr[1] = 15'h0004;
    d_req[1] = 1'b1; i_req[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("fix_d_gnt", d_gnt[1], 1);
      chk("fix_i_gnt", i_gnt[1], 0);
      if (d_gnt[1] === 1'b1) push_exp(2, 1'b1, 32'hA5A50000);
      @(posedge clk); #1;
    end
    d_req[1] = 1'b0;
    @(negedge clk);
    chk("fix_i_after_release", i_gnt[1], 1);
    if (i_gnt[1] === 1'b1) push_exp(3, 1'b1, 32'hA5A50001);
    @(posedge clk); #1;
    i_req[1] = 1'b0;
    drain(6);

    // Reset while an I read is in flight: no strobe, rdata cleared, memory kept.
    issue(1, 0, 1, 4'hF, 15'h0040, 32'h12345678, 0);
    drain(4);
    issue(1, 1, 0, 4'h0, 15'h0040, 0, 32'h12345678);
    do_reset(1, 2);
    @(negedge clk);
    chk("midflight_i_rdata", i_rdata[1], 0);
    chk("midflight_i_valid", i_valid[1], 0);
    drain(5);
    issue(1, 0, 0, 4'h0, 15'h0040, 0, 32'h12345678);
    // Write granted the cycle before reset has still committed.
    issue(1, 0, 1, 4'hF, 15'h0044, 32'hCAFEF00D, 0);
    do_reset(1, 1);
    issue(1, 0, 0, 4'h0, 15'h0044, 0, 32'hCAFEF00D);
    drain(5);

    // Full sweep: LCG pattern written backwards, read forwards on both ports.
    x = 32'h13579BDF;
    for (int w = 0; w < 8192; w++) begin
      x = x * 32'd1664525 + 32'd1013904223;
      pat[w] = x;
    end
    for (int w = 8191; w >= 0; w--) issue(0, 0, 1, 4'hF, 15'(w * 4), pat[w], 0);
    for (int w = 0; w < 8192; w++) begin
      issue(0, 0, 0, 4'h0, 15'(w * 4), 0, pat[w]);
      issue(0, 1, 0, 4'h0, 15'(w * 4), 0, pat[w]);
    end
    drain(8);

    for (int c = 0; c < 4; c++) chk($sformatf("sb_empty_ch%0d", c), sb[c].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
